// File: rtl/codec_sample_pkg.sv
// Shared sample type, saturation limits and the saturating adder
// used by the codec sample port.
package codec_sample_pkg;

  localparam int unsigned SAMPLE_W = 16;

  typedef logic [SAMPLE_W-1:0] sample_t;

  localparam sample_t SAT_POS = 16'h7FFF;
  localparam sample_t SAT_NEG = 16'h8000;

  // Two's-complement add with clamping; overflow shows as the two top sum bits differing.
  function automatic sample_t sat16(input sample_t a, input sample_t b);
    logic [SAMPLE_W:0] sum;
    sum = {a[SAMPLE_W-1], a} + {b[SAMPLE_W-1], b};
    if (sum[SAMPLE_W] != sum[SAMPLE_W-1]) begin
      return sum[SAMPLE_W] ? SAT_NEG : SAT_POS;
    end
    return sum[SAMPLE_W-1:0];
  endfunction

endpackage

// File: rtl/codec_frame_timer.sv
// Bit/frame timing for the codec port: BCK divider, slot counter, LRCK,
// frame-boundary strobe and the active-low SYNC pulse that follows it.
module codec_frame_timer #(
  parameter int unsigned BCK_DIV     = 4,
  parameter int unsigned FRAME_SLOTS = 64,
  parameter int unsigned SYNC_LEN    = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  output logic                           bck,
  output logic                           lrck,
  output logic                           sync,
  output logic                           fb,
  output logic                           bck_rise,
  output logic [$clog2(FRAME_SLOTS)-1:0] slot
);

  localparam int unsigned DIV_W  = $clog2(BCK_DIV);
  localparam int unsigned SLOT_W = $clog2(FRAME_SLOTS);
  localparam int unsigned SYNC_W = $clog2(SYNC_LEN + 1);

  logic [DIV_W-1:0]  div;
  logic [SYNC_W-1:0] sync_cnt;
  logic              div_last;
  logic              slot_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      div      <= '0;
      slot     <= '0;
      sync_cnt <= '0;
    end else begin
      if (div_last) begin
        div  <= '0;
        slot <= slot_last ? '0 : slot + 1'b1;
      end else begin
        div <= div + 1'b1;
      end
      // Loaded only at a frame boundary, so no pulse appears on reset release.
      if (fb) begin
        sync_cnt <= SYNC_W'(SYNC_LEN);
      end else if (sync_cnt != '0) begin
        sync_cnt <= sync_cnt - 1'b1;
      end
    end
  end

  always_comb begin
    div_last  = (div == DIV_W'(BCK_DIV - 1));
    slot_last = (slot == SLOT_W'(FRAME_SLOTS - 1));
    fb        = div_last && slot_last;
    bck_rise  = (div == DIV_W'(BCK_DIV / 2));
    bck       = (div >= DIV_W'(BCK_DIV / 2));
    lrck      = (slot >= SLOT_W'(FRAME_SLOTS / 2));
    sync      = (sync_cnt == '0);
  end

endmodule

// File: rtl/codec_sample_port.sv
// Serial codec front/back end for the delay chip: mono ADC deserializer,
// frame-boundary handoff to/from the chip, dry/wet mix and DAC serializer.
module codec_sample_port
  import codec_sample_pkg::*;
#(
  parameter int unsigned BCK_DIV       = 4,
  parameter int unsigned FRAME_SLOTS   = 64,
  parameter int unsigned SYNC_LEN      = 2,
  parameter int unsigned WARMUP_FRAMES = 4
) (
  input  logic                CLK_IN,
  input  logic                RESET,
  input  logic                ADC_SDATA,
  output logic                BCK,
  output logic                LRCK,
  output logic                DAC_SDATA,
  output logic                SYNC,
  output logic [SAMPLE_W-1:0] IO_TO_CHIP,
  input  logic [SAMPLE_W-1:0] IO_FROM_CHIP,
  input  logic                MUTE,
  input  logic                MIX_EN,
  output logic                SAMPLE_STB
);

  localparam int unsigned SLOT_W = $clog2(FRAME_SLOTS);
  localparam int unsigned HALF   = FRAME_SLOTS / 2;
  localparam int unsigned WARM_W = $clog2(WARMUP_FRAMES + 2);

  logic [SLOT_W-1:0] slot;
  logic [SLOT_W-1:0] half_pos;
  logic [3:0]        bit_idx;
  logic              bck_rise;
  logic              fb;
  sample_t           adc_sr;
  sample_t           dac_word;
  logic [WARM_W-1:0] warmup;

  codec_frame_timer #(
    .BCK_DIV    (BCK_DIV),
    .FRAME_SLOTS(FRAME_SLOTS),
    .SYNC_LEN   (SYNC_LEN)
  ) u_timer (
    .clk     (CLK_IN),
    .reset   (RESET),
    .bck     (BCK),
    .lrck    (LRCK),
    .sync    (SYNC),
    .fb      (fb),
    .bck_rise(bck_rise),
    .slot    (slot)
  );

  always_ff @(posedge CLK_IN) begin
    if (RESET) begin
      adc_sr     <= '0;
      dac_word   <= '0;
      IO_TO_CHIP <= '0;
      SAMPLE_STB <= 1'b0;
      warmup     <= WARM_W'(WARMUP_FRAMES);
    end else begin
      SAMPLE_STB <= fb;
      if (bck_rise && (slot < SLOT_W'(SAMPLE_W))) begin
        adc_sr <= {adc_sr[SAMPLE_W-2:0], ADC_SDATA};
      end
      // The chip word is consumed directly at the boundary rather than via a wet register.
      if (fb) begin
        IO_TO_CHIP <= adc_sr;
        if (MUTE || (warmup != '0)) begin
          dac_word <= '0;
        end else if (MIX_EN) begin
          dac_word <= sat16(adc_sr, IO_FROM_CHIP);
        end else begin
          dac_word <= IO_FROM_CHIP;
        end
        if (warmup != '0) begin
          warmup <= warmup - 1'b1;
        end
      end
    end
  end

  always_comb begin
    half_pos  = LRCK ? (slot - SLOT_W'(HALF)) : slot;
    bit_idx   = 4'(SAMPLE_W - 1) - half_pos[3:0];
    DAC_SDATA = (half_pos < SLOT_W'(SAMPLE_W)) ? dac_word[bit_idx] : 1'b0;
  end

endmodule
